mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequencer and arbiter that shares one 16-bit single-ported SRAM between the pipeline's instruction-fetch stage and memory stage. It serialises each 32-bit access into two half-word SRAM cycles with programmable wait states. It grants the memory stage over fetch and raises a pipeline freeze until every pending requester is served. It sits between the IF/MEM stages of the ARM pipeline and the external SRAM pins.

## Interface
- ADDR_W, 32, requester byte-address width
- SRAM_AW, 18, SRAM half-word address width
- WAIT_CYCLES, 4, cycles per SRAM half-word phase; legal 1..15
- clk  in  1  pipeline clock, rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- if_req  in  1  fetch read request, held until if_ready
- if_addr  in  ADDR_W  fetch byte address (bits [1:0] ignored)
- if_rdata  out  32  fetched word, valid when if_ready
- if_ready  out  1  one-cycle completion pulse for fetch
- mem_rd_req  in  1  data read request, held until mem_ready
- mem_wr_req  in  1  data write request, held until mem_ready
- mem_addr  in  ADDR_W  data byte address (bits [1:0] ignored)
- mem_wdata  in  32  write data
- mem_rdata  out  32  read word, valid when mem_ready
- mem_ready  out  1  one-cycle completion pulse for data access
- freeze  out  1  stall the pipeline
- sram_addr  out  SRAM_AW  half-word address
- sram_dq_out  out  16  write data to pad
- sram_dq_oe  out  1  pad output enable (1 = drive)
- sram_dq_in  in  16  read data from pad
- sram_we_n  out  1  write strobe, active-low

## Operation
- FSM states: IDLE, LO, HI, DONE. A 4-bit wait counter cnt runs within LO and HI.
- IDLE:
  - If mem_wr_req or mem_rd_req is high, grant MEM. Write wins if both are high.
  - Else if if_req is high, grant IF.
  - Else stay in IDLE.
  - On grant: latch owner, op, word address (addr[SRAM_AW:2]) and wdata. Set cnt=0 and go to LO.
- LO:
  - sram_addr = {word, 1'b0}.
  - On a write: sram_dq_oe=1 and sram_dq_out=wdata[15:0] for the whole phase. sram_we_n=0 while cnt<WAIT_CYCLES-1, and 1 on the last cycle.
  - At cnt==WAIT_CYCLES-1: on a read, capture sram_dq_in into data[15:0]. Then cnt=0 and go to HI. Otherwise cnt++.
- HI: same as LO with address {word, 1'b1}, upper half wdata[31:16], capture into data[31:16]. At the end go to DONE.
- DONE:
  - Pulse the owner's ready for one cycle.
  - On a read, present the captured word on the owner's rdata. The rdata register holds until the next capture.
  - Return to IDLE.
- Requests are re-sampled only in IDLE. Request or address changes mid-transaction are ignored.
- freeze = (mem_rd_req|mem_wr_req) & ~mem_ready | if_req & ~if_ready. This is the only combinational output; all others are registered.
- When MEM completes while if_req is pending, freeze stays high and IF is served next. A new MEM request still preempts at IDLE.

## Timing
- Reset (rst=0, asynchronous):
  - State = IDLE, cnt=0.
  - sram_we_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_out=0.
  - if_ready=mem_ready=0, if_rdata=mem_rdata=0.
- Reset mid-transaction aborts immediately. A partially written word is not guaranteed.
- Latency: request sampled in IDLE at cycle 0; ready is high in cycle 2*WAIT_CYCLES+1. Default: cycle 9, 10 cycles per access including IDLE.
- With WAIT_CYCLES=1, sram_we_n never goes low. WAIT_CYCLES≥2 is required for writes.
- Back-to-back: after DONE, one IDLE cycle always precedes the next grant.
- The sram_addr width truncates higher address bits, so the address wraps modulo 2^(SRAM_AW+1) bytes.

## Test plan
- Reset, then if_req=1, if_addr=0x10, SRAM returns 0x1111 at half-addr 8 and 0x2222 at half-addr 9:
  - if_ready pulses at cycle 9 with if_rdata=0x22221111.
  - freeze is high in cycles 0-8 and low in cycle 9.
- mem_wr_req with mem_addr=0x400, wdata=0xDEADBEEF:
  - sram_addr=0x200 with dq_out=0xBEEF, then 0x201 with dq_out=0xDEAD.
  - sram_we_n is low for 3 cycles per phase; mem_ready at cycle 9.
- if_req and mem_rd_req raised in the same cycle:
  - MEM is served first; mem_ready at cycle 9 while freeze stays high.
  - IDLE follows, then IF is granted; if_ready at cycle 19, and freeze falls only then.
- mem_wr_req and mem_rd_req both high → a write is performed (we_n pulses) and mem_rdata is unchanged.
- Reset asserted during the HI phase of a write → outputs go to reset values in the same cycle with no clock edge needed. After release, the FSM is in IDLE and no ready pulse occurs.
- WAIT_CYCLES=2 build, read at 0x0 → ready at cycle 5 with the correct word.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one 16-bit single-ported SRAM between the fetch and memory stages. Each 32-bit access
// is split into a low and a high half-word phase with a programmable number of wait cycles.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned SRAM_AW     = 18,
  parameter int unsigned WAIT_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_req,
  input  logic [ADDR_W-1:0]  if_addr,
  output logic [31:0]        if_rdata,
  output logic               if_ready,
  input  logic               mem_rd_req,
  input  logic               mem_wr_req,
  input  logic [ADDR_W-1:0]  mem_addr,
  input  logic [31:0]        mem_wdata,
  output logic [31:0]        mem_rdata,
  output logic               mem_ready,
  output logic               freeze,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_we_n
);

  localparam int unsigned WordW   = SRAM_AW - 1;
  localparam logic [3:0]  CntLast = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StLo, StHi, StDone} state_e;

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               owner_mem_q, owner_mem_d;
  logic               write_q, write_d;
  logic [WordW-1:0]   word_q, word_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [15:0]        data_lo_q, data_lo_d;
  logic [31:0]        if_rdata_q, if_rdata_d;
  logic [31:0]        mem_rdata_q, mem_rdata_d;
  logic               if_ready_q, if_ready_d;
  logic               mem_ready_q, mem_ready_d;
  logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
  logic [15:0]        sram_dq_out_q, sram_dq_out_d;
  logic               sram_dq_oe_q, sram_dq_oe_d;
  logic               sram_we_n_q, sram_we_n_d;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[ADDR_W-1:SRAM_AW+1], if_addr[1:0],
                              mem_addr[ADDR_W-1:SRAM_AW+1], mem_addr[1:0]};

  // Sequencing: grant, two timed half-word phases, then a one-cycle completion.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_mem_d = owner_mem_q;
    write_d     = write_q;
    word_d      = word_q;
    wdata_d     = wdata_q;
    data_lo_d   = data_lo_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_ready_d  = 1'b0;
    mem_ready_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mem_wr_req || mem_rd_req) begin
          owner_mem_d = 1'b1;
          write_d     = mem_wr_req;
          word_d      = mem_addr[SRAM_AW:2];
          wdata_d     = mem_wdata;
          cnt_d       = 4'd0;
          state_d     = StLo;
        end else if (if_req) begin
          owner_mem_d = 1'b0;
          write_d     = 1'b0;
          word_d      = if_addr[SRAM_AW:2];
          cnt_d       = 4'd0;
          state_d     = StLo;
        end
      end
      StLo: begin
        if (cnt_q == CntLast) begin
          if (!write_q) data_lo_d = sram_dq_in;
          cnt_d   = 4'd0;
          state_d = StHi;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StHi: begin
        if (cnt_q == CntLast) begin
          if (!write_q) begin
            if (owner_mem_q) mem_rdata_d = {sram_dq_in, data_lo_q};
            else             if_rdata_d  = {sram_dq_in, data_lo_q};
          end
          if (owner_mem_q) mem_ready_d = 1'b1;
          else             if_ready_d  = 1'b1;
          cnt_d   = 4'd0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Pad outputs are computed from the next state so they are registered yet phase-aligned.
  always_comb begin
    sram_addr_d   = sram_addr_q;
    sram_dq_out_d = sram_dq_out_q;
    sram_dq_oe_d  = 1'b0;
    sram_we_n_d   = 1'b1;
    if (state_d == StLo || state_d == StHi) begin
      sram_addr_d = {word_d, state_d == StHi};
      if (write_d) begin
        sram_dq_oe_d  = 1'b1;
        sram_dq_out_d = (state_d == StHi) ? wdata_d[31:16] : wdata_d[15:0];
        sram_we_n_d   = (cnt_d >= CntLast);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      cnt_q         <= 4'd0;
      owner_mem_q   <= 1'b0;
      write_q       <= 1'b0;
      word_q        <= '0;
      wdata_q       <= '0;
      data_lo_q     <= '0;
      if_rdata_q    <= '0;
      mem_rdata_q   <= '0;
      if_ready_q    <= 1'b0;
      mem_ready_q   <= 1'b0;
      sram_addr_q   <= '0;
      sram_dq_out_q <= '0;
      sram_dq_oe_q  <= 1'b0;
      sram_we_n_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      owner_mem_q   <= owner_mem_d;
      write_q       <= write_d;
      word_q        <= word_d;
      wdata_q       <= wdata_d;
      data_lo_q     <= data_lo_d;
      if_rdata_q    <= if_rdata_d;
      mem_rdata_q   <= mem_rdata_d;
      if_ready_q    <= if_ready_d;
      mem_ready_q   <= mem_ready_d;
      sram_addr_q   <= sram_addr_d;
      sram_dq_out_q <= sram_dq_out_d;
      sram_dq_oe_q  <= sram_dq_oe_d;
      sram_we_n_q   <= sram_we_n_d;
    end
  end

  assign if_rdata    = if_rdata_q;
  assign if_ready    = if_ready_q;
  assign mem_rdata   = mem_rdata_q;
  assign mem_ready   = mem_ready_q;
  assign sram_addr   = sram_addr_q;
  assign sram_dq_out = sram_dq_out_q;
  assign sram_dq_oe  = sram_dq_oe_q;
  assign sram_we_n   = sram_we_n_q;

  assign freeze = ((mem_rd_req | mem_wr_req) & ~mem_ready_q) | (if_req & ~if_ready_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: default build plus a WAIT_CYCLES=2 build, each backed by
// a small read-only SRAM array.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0, mem_rd_req = 1'b0, mem_wr_req = 1'b0;
  logic [31:0] if_addr = '0, mem_addr = '0, mem_wdata = '0;
  logic [31:0] if_rdata, mem_rdata;
  logic        if_ready, mem_ready, freeze, sram_dq_oe, sram_we_n;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;

  logic        b_if_req = 1'b0;
  logic [31:0] b_if_addr = '0;
  logic [31:0] b_if_rdata, b_mem_rdata;
  logic        b_if_ready, b_mem_ready, b_freeze, b_oe, b_we_n;
  logic [17:0] b_sram_addr;
  logic [15:0] b_dq_out, b_dq_in;

  logic [15:0] hw_mem [0:1023];
  logic [15:0] hw_mem2 [0:15];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign sram_dq_in = hw_mem[sram_addr[9:0]];
  assign b_dq_in    = hw_mem2[b_sram_addr[3:0]];

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .freeze(freeze), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
    .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n)
  );

  mem_port_arbiter #(.WAIT_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ready(b_if_ready),
    .mem_rd_req(1'b0), .mem_wr_req(1'b0), .mem_addr(32'h0),
    .mem_wdata(32'h0), .mem_rdata(b_mem_rdata), .mem_ready(b_mem_ready),
    .freeze(b_freeze), .sram_addr(b_sram_addr), .sram_dq_out(b_dq_out),
    .sram_dq_oe(b_oe), .sram_dq_in(b_dq_in), .sram_we_n(b_we_n)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step();
    step();
    checks++;
    if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 || sram_addr !== 18'h0 ||
        sram_dq_out !== 16'h0) begin
      errors++;
      $display("FAIL reset_pads: we_n=%b oe=%b addr=%h dq=%h, required 1 0 0 0",
               sram_we_n, sram_dq_oe, sram_addr, sram_dq_out);
    end
    checks++;
    if (if_ready !== 1'b0 || mem_ready !== 1'b0 || if_rdata !== 32'h0 || mem_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_outs: if_ready=%b mem_ready=%b if_rdata=%h mem_rdata=%h, required 0",
               if_ready, mem_ready, if_rdata, mem_rdata);
    end
    rst = 1'b1;
    step();
    checks++;
    if (freeze !== 1'b0) begin
      errors++;
      $display("FAIL reset_freeze: got %b, required 0", freeze);
    end
  endtask

  task automatic test_if_read();
    if_req  = 1'b1;
    if_addr = 32'h10;
    #1;
    checks++;
    if (freeze !== 1'b1) begin
      errors++;
      $display("FAIL if_read_freeze0: got %b, required 1", freeze);
    end
    for (int c = 1; c <= 9; c++) begin
      step();
      checks++;
      if (if_ready !== (c == 9) || freeze !== (c != 9)) begin
        errors++;
        $display("FAIL if_read_cycle%0d: if_ready=%b freeze=%b, required %b %b",
                 c, if_ready, freeze, c == 9, c != 9);
      end
      if (c >= 1 && c <= 8) begin
        checks++;
        if (sram_addr !== ((c <= 4) ? 18'h8 : 18'h9) || sram_dq_oe !== 1'b0) begin
          errors++;
          $display("FAIL if_read_addr%0d: addr=%h oe=%b, required %h 0",
                   c, sram_addr, sram_dq_oe, (c <= 4) ? 18'h8 : 18'h9);
        end
      end
    end
    checks++;
    if (if_rdata !== 32'h2222_1111) begin
      errors++;
      $display("FAIL if_read_data: got %h, required 22221111", if_rdata);
    end
    step();
    if_req = 1'b0;
    #1;
    checks++;
    if (if_ready !== 1'b0 || if_rdata !== 32'h2222_1111 || freeze !== 1'b0) begin
      errors++;
      $display("FAIL if_read_after: ready=%b rdata=%h freeze=%b, required 0 22221111 0",
               if_ready, if_rdata, freeze);
    end
  endtask

  task automatic test_write();
    logic exp_we_n;
    mem_wr_req = 1'b1;
    mem_addr   = 32'h400;
    mem_wdata  = 32'hDEAD_BEEF;
    for (int c = 1; c <= 9; c++) begin
      step();
      if (c <= 8) begin
        exp_we_n = (c == 4 || c == 8);
        checks++;
        if (sram_addr !== ((c <= 4) ? 18'h200 : 18'h201) ||
            sram_dq_out !== ((c <= 4) ? 16'hBEEF : 16'hDEAD) ||
            sram_dq_oe !== 1'b1 || sram_we_n !== exp_we_n || mem_ready !== 1'b0) begin
          errors++;
          $display("FAIL write_cycle%0d: addr=%h dq=%h oe=%b we_n=%b ready=%b, required we_n=%b",
                   c, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, mem_ready, exp_we_n);
        end
      end else begin
        checks++;
        if (mem_ready !== 1'b1 || sram_dq_oe !== 1'b0 || sram_we_n !== 1'b1 || freeze !== 1'b0) begin
          errors++;
          $display("FAIL write_done: ready=%b oe=%b we_n=%b freeze=%b, required 1 0 1 0",
                   mem_ready, sram_dq_oe, sram_we_n, freeze);
        end
      end
    end
    step();
    mem_wr_req = 1'b0;
  endtask

  task automatic test_priority();
    if_req     = 1'b1;
    if_addr    = 32'h30;
    mem_rd_req = 1'b1;
    mem_addr   = 32'h20;
    for (int c = 1; c <= 19; c++) begin
      step();
      if (c == 10) mem_rd_req = 1'b0;
      #1;
      checks++;
      if (mem_ready !== (c == 9) || if_ready !== (c == 19) || freeze !== (c != 19)) begin
        errors++;
        $display("FAIL prio_cycle%0d: mem_ready=%b if_ready=%b freeze=%b", c, mem_ready,
                 if_ready, freeze);
      end
      if (c == 2 || c == 12) begin
        checks++;
        if (sram_addr !== ((c == 2) ? 18'h10 : 18'h18)) begin
          errors++;
          $display("FAIL prio_addr%0d: got %h, required %h", c, sram_addr,
                   (c == 2) ? 18'h10 : 18'h18);
        end
      end
      if (c == 9) begin
        checks++;
        if (mem_rdata !== 32'h4444_3333) begin
          errors++;
          $display("FAIL prio_mem_data: got %h, required 44443333", mem_rdata);
        end
      end
    end
    checks++;
    if (if_rdata !== 32'h6666_5555) begin
      errors++;
      $display("FAIL prio_if_data: got %h, required 66665555", if_rdata);
    end
    step();
    if_req = 1'b0;
  endtask

  task automatic test_wr_rd();
    int low_cnt = 0;
    mem_wr_req = 1'b1;
    mem_rd_req = 1'b1;
    mem_addr   = 32'h40;
    mem_wdata  = 32'h1234_5678;
    for (int c = 1; c <= 9; c++) begin
      step();
      if (sram_we_n === 1'b0) low_cnt++;
      if (c == 1 || c == 5) begin
        checks++;
        if (sram_dq_oe !== 1'b1 || sram_dq_out !== ((c == 1) ? 16'h5678 : 16'h1234)) begin
          errors++;
          $display("FAIL wrrd_dq%0d: oe=%b dq=%h", c, sram_dq_oe, sram_dq_out);
        end
      end
    end
    checks++;
    if (mem_ready !== 1'b1 || mem_rdata !== 32'h4444_3333 || low_cnt != 6) begin
      errors++;
      $display("FAIL wrrd_done: ready=%b rdata=%h we_low=%0d, required 1 44443333 6",
               mem_ready, mem_rdata, low_cnt);
    end
    step();
    mem_wr_req = 1'b0;
    mem_rd_req = 1'b0;
  endtask

  task automatic test_reset_midway();
    int bad = 0;
    mem_wr_req = 1'b1;
    mem_addr   = 32'h400;
    mem_wdata  = 32'hAAAA_5555;
    for (int c = 1; c <= 6; c++) step();
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 || sram_addr !== 18'h0 ||
        sram_dq_out !== 16'h0 || mem_rdata !== 32'h0 || if_rdata !== 32'h0) begin
      errors++;
      $display("FAIL midrst_async: we_n=%b oe=%b addr=%h dq=%h mrd=%h ird=%h", sram_we_n,
               sram_dq_oe, sram_addr, sram_dq_out, mem_rdata, if_rdata);
    end
    mem_wr_req = 1'b0;
    step();
    rst = 1'b1;
    for (int c = 0; c < 12; c++) begin
      step();
      if (mem_ready !== 1'b0 || if_ready !== 1'b0 || sram_dq_oe !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL midrst_quiet: %0d cycles with activity, required 0", bad);
    end
    if_req  = 1'b1;
    if_addr = 32'h10;
    for (int c = 1; c <= 9; c++) begin
      step();
      if (c == 8 || c == 9) begin
        checks++;
        if (if_ready !== (c == 9)) begin
          errors++;
          $display("FAIL midrst_resume%0d: if_ready=%b, required %b", c, if_ready, c == 9);
        end
      end
    end
    checks++;
    if (if_rdata !== 32'h2222_1111) begin
      errors++;
      $display("FAIL midrst_data: got %h, required 22221111", if_rdata);
    end
    step();
    if_req = 1'b0;
  endtask

  task automatic test_wait2();
    b_if_req  = 1'b1;
    b_if_addr = 32'h0;
    for (int c = 1; c <= 5; c++) begin
      step();
      checks++;
      if (b_if_ready !== (c == 5) || b_freeze !== (c != 5)) begin
        errors++;
        $display("FAIL wait2_cycle%0d: ready=%b freeze=%b, required %b %b", c, b_if_ready,
                 b_freeze, c == 5, c != 5);
      end
    end
    checks++;
    if (b_if_rdata !== 32'hBABE_CAFE) begin
      errors++;
      $display("FAIL wait2_data: got %h, required babecafe", b_if_rdata);
    end
    step();
    b_if_req = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) hw_mem[i] = 16'h0;
    for (int i = 0; i < 16; i++) hw_mem2[i] = 16'h0;
    hw_mem[10'h8]  = 16'h1111;
    hw_mem[10'h9]  = 16'h2222;
    hw_mem[10'h10] = 16'h3333;
    hw_mem[10'h11] = 16'h4444;
    hw_mem[10'h18] = 16'h5555;
    hw_mem[10'h19] = 16'h6666;
    hw_mem2[0]     = 16'hCAFE;
    hw_mem2[1]     = 16'hBABE;
    test_reset();
    test_if_read();
    test_write();
    test_priority();
    test_wr_rd();
    test_reset_midway();
    test_wait2();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
